text_glyph_serializer: RTL and testbench
========================================

# text_glyph_serializer

Converts a stream of character cells (code, attribute, glyph row) into a one-pixel-per-clock stream of 4-bit colour indices. It sits directly downstream of the text glyph RAM: it drives the glyph RAM's read-only port (address, enable), captures the returned 8-bit glyph row, and shifts it out MSB-first. Its output feeds the palette lookup / video output stage. A one-cell look-ahead buffer gives gap-free output at full rate.

## Interface
- `GLYPH_ADDR_WIDTH`, default 12: glyph RAM address width; the address is `{code[7:0], row[3:0]}`.
- `BLINK_ATTR_BIT`, default 7: attribute bit that marks a blinking cell. Used only with `TEXT_BLINK_EN`.
- `clock`, in, 1: single clock for all logic, including the glyph RAM port A clock.
- `reset`, in, 1: synchronous, active-high.
- `cellValid`, in, 1: a cell is offered.
- `cellReady`, out, 1: the block accepts the cell this cycle.
- `cellCode`, in, 8: character code point.
- `cellAttr`, in, 8: `[3:0]` foreground, `[6:4]` background (zero-extended to 4 bits), `[7]` blink.
- `cellRow`, in, 4: glyph scanline 0–15.
- `blinkPhase`, in, 1: blink phase from video timing. Used only with `TEXT_BLINK_EN`.
- `glyphEnable`, out, 1: glyph RAM port A enable.
- `glyphAddress`, out, 12: glyph RAM port A address.
- `glyphData`, in, 8: glyph RAM read data. Valid one cycle after `glyphEnable`.
- `pixelValid`, out, 1: `pixelColor` is a live pixel.
- `pixelColor`, out, 4: colour index.
- `busy`, out, 1: a fetch is in flight, the look-ahead buffer is full, or the shifter is active.

## Operation
- **Acceptance.** A cell is accepted when `cellValid && cellReady`. `cellReady` = `!fetchPending && !nextFull`.
- **Fetch.** In the acceptance cycle T:
  - `glyphEnable`=1 and `glyphAddress`=`{cellCode, cellRow}`, both combinational from the inputs and gated by accept.
  - `cellAttr` is registered and `fetchPending` is set.
- **Capture.** At the end of T+1, `glyphData` and the registered attribute load the look-ahead buffer: `nextFull`=1, `fetchPending`=0.
- **States** (2-state shifter FSM):
  - IDLE → SHIFT when `nextFull`. The shifter is loaded from the buffer and the buffer empties.
  - SHIFT: 3-bit `bitIndex` counts 0..7. One pixel per clock, MSB first.
  - At `bitIndex`==7: if `nextFull` (including a capture completing this same cycle), reload with no gap and stay in SHIFT. Otherwise go to IDLE.
- **Pixel value.** Pixel = glyph bit ? fg : bg. Registered into `pixelColor` with `pixelValid`=1.
- **IDLE outputs.** `pixelValid`=0 and `pixelColor`=0.
- **Simultaneous events.**
  - The buffer may be loaded (capture) and drained (shifter reload) in the same cycle. The shifter takes the captured value directly; `nextFull` stays 0.
  - `cellReady` is not re-raised in that cycle because `fetchPending` is still 1.
- **Throughput.** Steady state is 1 cell per 8 clocks. The upstream cell fetcher must offer each cell within 6 clocks of `cellReady` rising to avoid a gap.
- **`cellRow` range.** All 16 values are legal. There is no wrap logic; the address is a pure concatenation.
- **Reset, any cycle, mid-operation.** Clears FSM to IDLE, `bitIndex`, `fetchPending`, `nextFull`, and the shift/attribute registers. Any in-flight RAM data is discarded.
- **Reset output values:** `cellReady`=0 while reset is high and 1 the cycle after; `glyphEnable`=0, `glyphAddress`=0, `pixelValid`=0, `pixelColor`=0, `busy`=0.

## Timing
- Cell accepted at T → `glyphEnable` at T → data at T+1 → first pixel registered at the end of T+2, visible in cycle T+3.
- Latency from accept to first `pixelValid` is 3 clocks. Each pixel lasts exactly 1 clock.
- `glyphData` is sampled only in the cycle following `glyphEnable`.
- No combinational path from `glyphData` to any output.

## Configuration
- **`TEXT_BLINK_EN` defined:** when `cellAttr[BLINK_ATTR_BIT]`=1 and `blinkPhase`=1, every pixel of that cell outputs bg. `blinkPhase` is sampled at shifter load, so a cell never changes mid-glyph.
- **`TEXT_BLINK_EN` undefined:**
  - Bit 7 is ignored and `blinkPhase` is unused.
  - Background stays 3 bits zero-extended (bit 7 is not promoted to a bright background).

## Structure
- Shared package `TextRenderPkg`:
  - `GLYPH_WIDTH`=8, `GLYPH_HEIGHT`=16.
  - Attribute field offsets (FG_LSB=0, BG_LSB=4, BLINK_BIT=7).
  - Typedef `glyph_cell_t` {glyph[7:0], fg[3:0], bg[3:0], blink}.
- One sub-module, `text_glyph_shift_reg`: load, shift, `bitIndex` counter, and the fg/bg mux. The top module holds the handshake, fetch, and look-ahead buffer.

## Test plan
- **Reset:** assert reset 3 cycles mid-shift → all outputs 0. `cellReady`=1 the cycle after release. No stale pixels afterwards.
- **Single cell:** code 0x41, row 5, attr 0x1F, RAM word 0xC3 → `glyphAddress`=0x415 at T. Pixels from T+3 are F,F,1,1,1,1,F,F, then `pixelValid`=0.
- **Back-to-back:** 4 cells offered whenever `cellReady` is high → 32 consecutive `pixelValid` cycles with no gap. `glyphEnable` pulses exactly 4 times.
- **Starvation:** second cell offered 10 clocks after the first is accepted → `pixelValid` drops after 8 pixels and resumes 3 clocks after accept.
- **Blink (`TEXT_BLINK_EN`):** attr 0x9E, `blinkPhase`=1, glyph 0xFF → 8 pixels of 1. With `blinkPhase`=0 → 8 pixels of E. Without the macro → E in both cases.
- **Row bounds:** row 0 and row 15 with code 0xFF → addresses 0xFF0 and 0xFFF. Correct data is returned.

Source files
------------

// File: rtl/text_glyph_serializer_pkg.sv
// Shared text-render types: glyph geometry, attribute field offsets and the cell record
// handed from the look-ahead buffer to the pixel shifter.
package TextRenderPkg;

    localparam int GLYPH_WIDTH  = 8;
    localparam int GLYPH_HEIGHT = 16;

    localparam int FG_LSB    = 0;
    localparam int BG_LSB    = 4;
    localparam int BLINK_BIT = 7;

    typedef struct packed {
        logic [7:0] glyph;
        logic [3:0] fg;
        logic [3:0] bg;
        logic       blink;
    } glyph_cell_t;

    typedef enum logic {
        SHIFT_IDLE = 1'b0,
        SHIFT_RUN  = 1'b1
    } shift_state_t;

endpackage

// File: rtl/text_glyph_serializer_shift_reg.sv
// Glyph row shifter: loads a cell, emits one colour index per clock MSB-first.
// Optional TEXT_BLINK_EN blanks blinking cells to background at load time.
module text_glyph_shift_reg
    import TextRenderPkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        bufFull,
    input  logic        captureNow,
    input  logic        blinkPhase,
    input  glyph_cell_t bufCell,
    input  glyph_cell_t captureCell,
    output logic        take,
    output logic        active,
    output logic        pixelValid,
    output logic [3:0]  pixelColor
);

    localparam logic [2:0] LAST_BIT = 3'(GLYPH_WIDTH - 1);

    shift_state_t state;
    logic [7:0]   shiftBits;
    logic [3:0]   fgReg;
    logic [3:0]   bgReg;
    logic [2:0]   bitIndex;
    glyph_cell_t  src;
    logic [7:0]   srcGlyph;

    function automatic logic [3:0] pixel_mux(input logic bitVal, input logic [3:0] fg,
                                             input logic [3:0] bg);
        return bitVal ? fg : bg;
    endfunction

    // A capture landing in the last-pixel cycle is taken straight off the RAM bus.
    always_comb begin
        src      = bufFull ? bufCell : captureCell;
        srcGlyph = src.glyph;
`ifdef TEXT_BLINK_EN
        if (src.blink && blinkPhase)
            srcGlyph = '0;
`endif
        if (state == SHIFT_IDLE)
            take = bufFull;
        else
            take = (bitIndex == LAST_BIT) && (bufFull || captureNow);
    end

`ifndef TEXT_BLINK_EN
    logic unused_blink;
    assign unused_blink = blinkPhase ^ src.blink;
`endif

    assign active = (state == SHIFT_RUN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SHIFT_IDLE;
            shiftBits  <= '0;
            fgReg      <= '0;
            bgReg      <= '0;
            bitIndex   <= '0;
            pixelValid <= 1'b0;
            pixelColor <= '0;
        end else if (take) begin
            state      <= SHIFT_RUN;
            shiftBits  <= {srcGlyph[6:0], 1'b0};
            fgReg      <= src.fg;
            bgReg      <= src.bg;
            bitIndex   <= '0;
            pixelValid <= 1'b1;
            pixelColor <= pixel_mux(srcGlyph[7], src.fg, src.bg);
        end else if (state == SHIFT_RUN) begin
            if (bitIndex == LAST_BIT) begin
                state      <= SHIFT_IDLE;
                bitIndex   <= '0;
                pixelValid <= 1'b0;
                pixelColor <= '0;
            end else begin
                bitIndex   <= bitIndex + 3'd1;
                shiftBits  <= {shiftBits[6:0], 1'b0};
                pixelColor <= pixel_mux(shiftBits[7], fgReg, bgReg);
            end
        end
    end

endmodule

// File: rtl/text_glyph_serializer.sv
// Character-cell to pixel serializer: cell handshake, glyph RAM fetch, one-cell look-ahead.
// Optional feature macro: TEXT_BLINK_EN (blinking cells render as background).
module text_glyph_serializer
    import TextRenderPkg::*;
#(
    parameter int GLYPH_ADDR_WIDTH = 12,
    parameter int BLINK_ATTR_BIT   = 7
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cellValid,
    output logic                        cellReady,
    input  logic [7:0]                  cellCode,
    input  logic [7:0]                  cellAttr,
    input  logic [3:0]                  cellRow,
    input  logic                        blinkPhase,
    output logic                        glyphEnable,
    output logic [GLYPH_ADDR_WIDTH-1:0] glyphAddress,
    input  logic [7:0]                  glyphData,
    output logic                        pixelValid,
    output logic [3:0]                  pixelColor,
    output logic                        busy
);

    logic        fetchPending;
    logic        nextFull;
    logic        accept;
    logic        take;
    logic        active;
    logic [7:0]  attrReg;
    glyph_cell_t bufCell;
    glyph_cell_t captureCell;

    assign cellReady    = !reset && !fetchPending && !nextFull;
    assign accept       = cellValid && cellReady;
    assign glyphEnable  = accept;
    assign glyphAddress = accept ? GLYPH_ADDR_WIDTH'({cellCode, cellRow}) : '0;
    assign busy         = fetchPending || nextFull || active;

    always_comb begin
        captureCell       = '0;
        captureCell.glyph = glyphData;
        captureCell.fg    = attrReg[FG_LSB +: 4];
        captureCell.bg    = {1'b0, attrReg[BG_LSB +: 3]};
        captureCell.blink = attrReg[BLINK_ATTR_BIT];
    end

    // RAM data is only meaningful the cycle after the fetch, so capture is keyed on fetchPending.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetchPending <= 1'b0;
            nextFull     <= 1'b0;
            attrReg      <= '0;
            bufCell      <= '0;
        end else begin
            if (accept)
                attrReg <= cellAttr;
            fetchPending <= accept;
            if (fetchPending) begin
                bufCell  <= captureCell;
                nextFull <= !take;
            end else if (take) begin
                nextFull <= 1'b0;
            end
        end
    end

    text_glyph_shift_reg u_shift (
        .clock       (clock),
        .reset       (reset),
        .bufFull     (nextFull),
        .captureNow  (fetchPending),
        .blinkPhase  (blinkPhase),
        .bufCell     (bufCell),
        .captureCell (captureCell),
        .take        (take),
        .active      (active),
        .pixelValid  (pixelValid),
        .pixelColor  (pixelColor)
    );

endmodule

// File: tb/tb_text_glyph_serializer.sv
// Self-checking bench for text_glyph_serializer: glyph RAM model, cell-level pixel model,
// per-cycle compare plus literal expectations from hand-worked examples.
module tb_text_glyph_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cellValid;
    logic        cellReady;
    logic [7:0]  cellCode;
    logic [7:0]  cellAttr;
    logic [3:0]  cellRow;
    logic        blinkPhase;
    logic        glyphEnable;
    logic [11:0] glyphAddress;
    logic [7:0]  glyphData = 8'h00;
    logic        pixelValid;
    logic [3:0]  pixelColor;
    logic        busy;

    text_glyph_serializer dut (
        .clock        (clock),
        .reset        (reset),
        .cellValid    (cellValid),
        .cellReady    (cellReady),
        .cellCode     (cellCode),
        .cellAttr     (cellAttr),
        .cellRow      (cellRow),
        .blinkPhase   (blinkPhase),
        .glyphEnable  (glyphEnable),
        .glyphAddress (glyphAddress),
        .glyphData    (glyphData),
        .pixelValid   (pixelValid),
        .pixelColor   (pixelColor),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [4096];

    always @(posedge clock) begin
        if (glyphEnable) glyphData <= mem[glyphAddress];
        else             glyphData <= 8'($urandom);
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit checkOn = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Cell-level model: each accepted cell owns 8 future pixel slots.
    bit         expValid [4096];
    logic [3:0] expColor [4096];
    bit         expBusy  [4096];
    int         prevEnd = -100;
    int         enCount, run, maxRun, lastAccept;
    logic [11:0] lastAddr;
    logic [3:0] pq[$];
    int         pixCyc[$];
    int         tAcc, start;
    logic [11:0] addr;
    logic [7:0] g;

    always @(negedge clock) begin
        if (checkOn && cyc < 4096) begin
            chk("pixel_valid", pixelValid, expValid[cyc]);
            chk("pixel_color", pixelColor, expValid[cyc] ? expColor[cyc] : 4'h0);
            chk("busy", busy, expBusy[cyc]);
        end
        if (pixelValid) begin
            pq.push_back(pixelColor);
            pixCyc.push_back(cyc);
            run++;
            if (run > maxRun) maxRun = run;
        end else begin
            run = 0;
        end
        if (glyphEnable) enCount++;
        if (reset) begin
            for (int k = cyc + 1; k < 4096; k++) begin
                expValid[k] = 0;
                expBusy[k]  = 0;
            end
            prevEnd = -100;
            if (checkOn) begin
                chk("reset_ready", cellReady, 0);
                chk("reset_enable", glyphEnable, 0);
                chk("reset_addr", glyphAddress, 0);
            end
        end else if (cellValid && cellReady) begin
            tAcc = cyc;
            addr = {cellCode, cellRow};
            lastAccept = cyc;
            lastAddr = glyphAddress;
            chk("fetch_enable", glyphEnable, 1);
            chk("fetch_addr", glyphAddress, addr);
            start = (tAcc + 1 <= prevEnd) ? prevEnd + 1 : tAcc + 3;
            g = mem[addr];
`ifdef TEXT_BLINK_EN
            if (cellAttr[7] && blinkPhase) g = 8'h00;
`endif
            for (int i = 0; i < 8; i++) begin
                if (start + i < 4096) begin
                    expValid[start + i] = 1;
                    expColor[start + i] = g[7 - i] ? cellAttr[3:0] : {1'b0, cellAttr[6:4]};
                end
            end
            for (int k = tAcc + 1; k <= start + 7 && k < 4096; k++) expBusy[k] = 1;
            prevEnd = start + 7;
        end else if (checkOn) begin
            chk("idle_enable", glyphEnable, 0);
        end
    end

    task automatic clear_log();
        pq.delete();
        pixCyc.delete();
        enCount = 0;
        maxRun  = 0;
    endtask

    task automatic offer(input logic [7:0] c, input logic [3:0] r, input logic [7:0] a);
        int n = 0;
        cellCode = c; cellRow = r; cellAttr = a; cellValid = 1'b1;
        while (1) begin
            @(negedge clock);
            if (cellReady) break;
            n++;
            if (n > 50) begin
                chk("ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clock); #1;
        cellValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge clock);
            if (!busy && !pixelValid) break;
            n++;
            if (n > 100) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    logic [3:0] expSingle [8] = '{4'hF, 4'hF, 4'h1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF};
    int acc1, acc2, sz;
    logic [3:0] blinkOn;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cellValid = 1'b0; cellCode = '0; cellRow = '0; cellAttr = '0;
        blinkPhase = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 37) ^ (i >> 3));
        mem[12'h415] = 8'hC3;
        mem[12'h102] = 8'hFF;
        mem[12'hFF0] = 8'h81;
        mem[12'hFFF] = 8'h7E;

        repeat (3) @(posedge clock);
        #1 checkOn = 1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", cellReady, 1);
        chk("pixel_after_reset", pixelValid, 0);
        @(posedge clock); #1;

        // Single cell
        clear_log();
        offer(8'h41, 4'h5, 8'h1F);
        chk("single_addr", lastAddr, 12'h415);
        wait_idle();
        chk("single_count", pq.size(), 8);
        if (pq.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("single_pixel", pq[i], expSingle[i]);
            chk("single_latency", pixCyc[0] - lastAccept, 3);
        end

        // Back-to-back
        clear_log();
        offer(8'h20, 4'h0, 8'h17);
        offer(8'h31, 4'h3, 8'h5A);
        offer(8'h7E, 4'h9, 8'h0C);
        offer(8'hA5, 4'hE, 8'h63);
        wait_idle();
        chk("b2b_enables", enCount, 4);
        chk("b2b_run", maxRun, 32);
        chk("b2b_count", pq.size(), 32);

        // Starvation
        clear_log();
        offer(8'h41, 4'h5, 8'h1F);
        acc1 = lastAccept;
        repeat (9) @(posedge clock);
        #1;
        offer(8'h41, 4'h5, 8'h2E);
        acc2 = lastAccept;
        chk("starve_accept_gap", acc2 - acc1, 10);
        wait_idle();
        chk("starve_count", pq.size(), 16);
        if (pq.size() == 16) begin
            chk("starve_first_run", pixCyc[7] - pixCyc[0], 7);
            chk("starve_resume", pixCyc[8] - acc2, 3);
            chk("starve_second_color", pq[8], 4'hE);
        end

        // Reset mid-shift with a second cell queued
        clear_log();
        offer(8'h55, 4'h1, 8'h4B);
        offer(8'h66, 4'h2, 8'h3C);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst_pixel_valid", pixelValid, 0);
        chk("rst_pixel_color", pixelColor, 0);
        chk("rst_busy", busy, 0);
        @(posedge clock); @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_ready_release", cellReady, 1);
        sz = pq.size();
        repeat (15) @(posedge clock);
        #1;
        chk("rst_no_stale", pq.size(), sz);

        // Blink
`ifdef TEXT_BLINK_EN
        blinkOn = 4'h1;
`else
        blinkOn = 4'hE;
`endif
        clear_log();
        blinkPhase = 1'b1;
        offer(8'h10, 4'h2, 8'h9E);
        wait_idle();
        chk("blink1_count", pq.size(), 8);
        if (pq.size() == 8) for (int i = 0; i < 8; i++) chk("blink1_pixel", pq[i], blinkOn);
        clear_log();
        blinkPhase = 1'b0;
        offer(8'h10, 4'h2, 8'h9E);
        wait_idle();
        chk("blink0_count", pq.size(), 8);
        if (pq.size() == 8) for (int i = 0; i < 8; i++) chk("blink0_pixel", pq[i], 4'hE);

        // Row bounds
        clear_log();
        offer(8'hFF, 4'h0, 8'h2A);
        chk("row0_addr", lastAddr, 12'hFF0);
        wait_idle();
        if (pq.size() == 8) begin
            chk("row0_first", pq[0], 4'hA);
            chk("row0_mid", pq[3], 4'h2);
        end else chk("row0_count", pq.size(), 8);
        clear_log();
        offer(8'hFF, 4'hF, 8'h2A);
        chk("row15_addr", lastAddr, 12'hFFF);
        wait_idle();
        if (pq.size() == 8) begin
            chk("row15_first", pq[0], 4'h2);
            chk("row15_mid", pq[3], 4'hA);
        end else chk("row15_count", pq.size(), 8);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
